sha1_arbiter: RTL

Shares the single sha1_core between two requesters: requester 0 is the TOTP controller; requester 1 is the EPP-side host self-test/HMAC path.
Grants ownership of the core for a whole multi-block message, because the core keeps chaining state between blocks.
Sequences init/next pulses and tracks the core's ready handshake.
Returns each block's digest to the owning requester.
Sits between the requesters and sha1_core in main.

---
 rtl/sha1_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sha1_arbiter.sv
// Shares one sha1_core between two requesters, granting ownership for a whole multi-block message.
// Define ARB_STATS_EN to add per-requester block counters and an error counter.
module sha1_arbiter #(
    parameter int FIXED_PRI  = 0,
    parameter int WAIT_LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         first0,
    input  logic         last0,
    input  logic [511:0] block0,
    output logic         ack0,
    output logic         gnt0,
    output logic         done0,
    input  logic         req1,
    input  logic         first1,
    input  logic         last1,
    input  logic [511:0] block1,
    output logic         ack1,
    output logic         gnt1,
    output logic         done1,
    output logic [159:0] digest,
    output logic         err,
    output logic         sha1_init,
    output logic         sha1_next,
    output logic [511:0] sha1_block,
`ifdef ARB_STATS_EN
    output logic [15:0]  blk_cnt0,
    output logic [15:0]  blk_cnt1,
    output logic [7:0]   err_cnt,
`endif
    input  logic         sha1_ready,
    input  logic [159:0] sha1_digest
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

    state_t         state, state_n;
    logic           owner, owner_n;
    logic           rr_ptr, rr_ptr_n;
    logic           last_q, last_n;
    logic [CW-1:0]  wait_cnt, wait_cnt_n;
    logic           gnt0_n, gnt1_n, ack0_n, ack1_n, done0_n, done1_n;
    logic           err_n, init_n, next_n;
    logic [511:0]   block_n;
    logic [159:0]   digest_n;
    logic           pick;
    logic           own_req, own_first, own_last;
    logic [511:0]   own_block;

    assign own_req   = owner ? req1   : req0;
    assign own_first = owner ? first1 : first0;
    assign own_last  = owner ? last1  : last0;
    assign own_block = owner ? block1 : block0;

    // All outputs are registered; this block computes their next values.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        last_n     = last_q;
        wait_cnt_n = wait_cnt;
        gnt0_n     = gnt0;
        gnt1_n     = gnt1;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        done0_n    = 1'b0;
        done1_n    = 1'b0;
        err_n      = 1'b0;
        init_n     = 1'b0;
        next_n     = 1'b0;
        block_n    = sha1_block;
        digest_n   = digest;
        pick       = req1;
        if (req0 && req1) begin
            pick = (FIXED_PRI != 0) ? 1'b0 : rr_ptr;
        end

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_n    = pick;
                    gnt0_n     = ~pick;
                    gnt1_n     = pick;
                    ack0_n     = ~pick;
                    ack1_n     = pick;
                    block_n    = pick ? block1 : block0;
                    last_n     = pick ? last1 : last0;
                    init_n     = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!sha1_ready) begin
                    state_n = WAIT_DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    err_n   = 1'b1;
                    gnt0_n  = 1'b0;
                    gnt1_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (sha1_ready) begin
                    digest_n = sha1_digest;
                    done0_n  = ~owner;
                    done1_n  = owner;
                    if (last_q) begin
                        gnt0_n   = 1'b0;
                        gnt1_n   = 1'b0;
                        rr_ptr_n = ~owner;
                        state_n  = IDLE;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                // The core holds chaining state, so only the owner may continue.
                if (own_req) begin
                    ack0_n     = ~owner;
                    ack1_n     = owner;
                    block_n    = own_block;
                    last_n     = own_last;
                    init_n     = own_first;
                    next_n     = ~own_first;
                    wait_cnt_n = '0;
                    state_n    = WAIT_BUSY;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            last_q     <= 1'b0;
            wait_cnt   <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            sha1_init  <= 1'b0;
            sha1_next  <= 1'b0;
            sha1_block <= '0;
            digest     <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            rr_ptr     <= rr_ptr_n;
            last_q     <= last_n;
            wait_cnt   <= wait_cnt_n;
            gnt0       <= gnt0_n;
            gnt1       <= gnt1_n;
            ack0       <= ack0_n;
            ack1       <= ack1_n;
            done0      <= done0_n;
            done1      <= done1_n;
            err        <= err_n;
            sha1_init  <= init_n;
            sha1_next  <= next_n;
            sha1_block <= block_n;
            digest     <= digest_n;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt0 <= '0;
            blk_cnt1 <= '0;
            err_cnt  <= '0;
        end else begin
            if (done0_n && blk_cnt0 != 16'hFFFF) blk_cnt0 <= blk_cnt0 + 16'd1;
            if (done1_n && blk_cnt1 != 16'hFFFF) blk_cnt1 <= blk_cnt1 + 16'd1;
            if (err_n && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
